// File: rtl/memwb_pipe_pkg.sv
// Shared core definitions for the MEM/WB boundary: RISC-V load funct3 codes
// and the byte-select width helper.
package memwb_pipe_pkg;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LD  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;
  localparam logic [2:0] LT_LWU = 3'b110;

  function automatic int bsel_w(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/memwb_pipe_load_ext.sv
// Combinational load extraction: picks byte/half/word out of the raw memory
// word at byte_sel and sign- or zero-extends it according to funct3.
module load_ext
  import memwb_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BSW  = bsel_w(XLEN)
) (
  input  logic [XLEN-1:0] data,
  input  logic [BSW-1:0]  byte_sel,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;

  // Halfword and word offsets ignore the low select bits (natural alignment).
  always_comb begin
    b = data[8 * int'(byte_sel) +: 8];
    h = data[16 * int'(byte_sel >> 1) +: 16];
    w = data[32 * int'(byte_sel >> 2) +: 32];
  end

  always_comb begin
    ext = data;
    case (load_type)
      LT_LB:   ext = XLEN'($signed(b));
      LT_LH:   ext = XLEN'($signed(h));
      LT_LW:   ext = XLEN'($signed(w));
      LT_LBU:  ext = XLEN'(b);
      LT_LHU:  ext = XLEN'(h);
      LT_LWU:  ext = (XLEN == 64) ? XLEN'(w) : data;
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/memwb_pipe.sv
// MEM/WB pipeline register with a two-entry skid buffer so ready_m never
// depends combinationally on ready_w.
module memwb_pipe
  import memwb_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5,
  parameter int RW_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    valid_m,
  output logic                    ready_m,
  input  logic [XLEN-1:0]         alu_out_m,
  input  logic [XLEN-1:0]         ram_data_m,
  input  logic [XLEN-1:0]         result_m,
  input  logic [RD_W-1:0]         rd_m,
  input  logic [RW_W-1:0]         reg_write_m,
  input  logic                    mem_to_reg_m,
  input  logic [2:0]              load_type_m,
  output logic                    valid_w,
  input  logic                    ready_w,
  output logic [XLEN-1:0]         result_w,
  output logic [XLEN-1:0]         load_data_w,
  output logic [RD_W-1:0]         rd_w,
  output logic [RW_W-1:0]         reg_write_w,
  output logic                    mem_to_reg_w,
  output logic [bsel_w(XLEN)-1:0] byte_sel_w
);

  localparam int BSW = bsel_w(XLEN);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] ram_data;
    logic [RD_W-1:0] rd;
    logic [RW_W-1:0] reg_write;
    logic            mem_to_reg;
    logic [2:0]      load_type;
    logic [BSW-1:0]  byte_sel;
  } entry_t;

  entry_t main_q, skid_q, entry_in;
  logic   main_valid, skid_valid;
  logic   in_fire, out_fire;
  logic   unused_alu;

  assign unused_alu = ^alu_out_m[XLEN-1:BSW];

  assign entry_in = '{result:     result_m,
                      ram_data:   ram_data_m,
                      rd:         rd_m,
                      reg_write:  reg_write_m,
                      mem_to_reg: mem_to_reg_m,
                      load_type:  load_type_m,
                      byte_sel:   alu_out_m[BSW-1:0]};

  assign ready_m  = ~skid_valid;
  assign valid_w  = main_valid;
  assign in_fire  = valid_m & ready_m;
  assign out_fire = valid_w & ready_w;

  // While skid is full ready_m is low, so no input can arrive in that branch.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (skid_valid) begin
      if (out_fire) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid || out_fire) begin
        main_q     <= entry_in;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= entry_in;
        skid_valid <= 1'b1;
      end
    end else if (out_fire) begin
      main_valid <= 1'b0;
    end
  end

  assign result_w     = main_q.result;
  assign rd_w         = main_q.rd;
  assign reg_write_w  = main_valid ? main_q.reg_write : '0;
  assign mem_to_reg_w = main_q.mem_to_reg;
  assign byte_sel_w   = main_q.byte_sel;

  load_ext #(.XLEN(XLEN), .BSW(BSW)) u_load_ext (
    .data      (main_q.ram_data),
    .byte_sel  (main_q.byte_sel),
    .load_type (main_q.load_type),
    .ext       (load_data_w)
  );

endmodule

// File: tb/tb_memwb_pipe.sv
// Bench for memwb_pipe: table of load/pass-through vectors checked through a
// scoreboard queue, plus hand sequences for backpressure, stall, flush, reset.
module tb_memwb_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, valid_m, ready_w;
  logic        ready_m, valid_w, mem_to_reg_m, mem_to_reg_w;
  logic [31:0] alu_out_m, ram_data_m, result_m, result_w, load_data_w;
  logic [4:0]  rd_m, rd_w;
  logic [2:0]  reg_write_m, reg_write_w, load_type_m;
  logic [1:0]  byte_sel_w;

  memwb_pipe #(.XLEN(32), .RD_W(5), .RW_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .valid_m(valid_m), .ready_m(ready_m),
    .alu_out_m(alu_out_m), .ram_data_m(ram_data_m), .result_m(result_m),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .load_type_m(load_type_m),
    .valid_w(valid_w), .ready_w(ready_w),
    .result_w(result_w), .load_data_w(load_data_w), .rd_w(rd_w),
    .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w),
    .byte_sel_w(byte_sel_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, ram;
    logic [2:0]  lt;
    logic [31:0] res;
    logic [4:0]  rd;
    logic [2:0]  rw;
    logic        m2r;
    logic [31:0] ld;
  } vec_t;

  typedef struct {
    logic [31:0] res, ld;
    logic [4:0]  rd;
    logic [2:0]  rw;
    logic        m2r;
    logic [1:0]  bs;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t cur;
  vec_t tbl[12];
  vec_t va, vb, vc, vd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic send(input vec_t v);
    alu_out_m    = v.alu;
    ram_data_m   = v.ram;
    load_type_m  = v.lt;
    result_m     = v.res;
    rd_m         = v.rd;
    reg_write_m  = v.rw;
    mem_to_reg_m = v.m2r;
    valid_m      = 1'b1;
    cur.res = v.res; cur.ld = v.ld; cur.rd = v.rd;
    cur.rw = v.rw; cur.m2r = v.m2r; cur.bs = v.alu[1:0];
  endtask

  // Called just after a falling edge with inputs driven; models one clock.
  task automatic cycle();
    exp_t e;
    #1;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (valid_w && ready_w) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_output", {32'h0, result_w}, 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          e = sb.pop_front();
          chk("sb_result",    result_w,     e.res);
          chk("sb_load_data", load_data_w,  e.ld);
          chk("sb_rd",        rd_w,         e.rd);
          chk("sb_reg_write", reg_write_w,  e.rw);
          chk("sb_mem_to_reg",mem_to_reg_w, e.m2r);
          chk("sb_byte_sel",  byte_sel_w,   e.bs);
        end
      end
      if (valid_m && ready_m) sb.push_back(cur);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready_m"},   ready_m,      1'b1);
    chk({tag, "_valid_w"},   valid_w,      1'b0);
    chk({tag, "_result_w"},  result_w,     32'h0);
    chk({tag, "_load_data"}, load_data_w,  32'h0);
    chk({tag, "_rd_w"},      rd_w,         5'h0);
    chk({tag, "_reg_write"}, reg_write_w,  3'h0);
    chk({tag, "_mem_to_reg"},mem_to_reg_w, 1'b0);
    chk({tag, "_byte_sel"},  byte_sel_w,   2'h0);
  endtask

  initial begin
    //          alu          ram           lt      res           rd  rw     m2r   expected load
    tbl[0]  = '{32'h0,       32'h0,        3'b010, 32'h0000_1234, 7, 3'b001, 1'b0, 32'h0};
    tbl[1]  = '{32'h3,       32'h80FF_7F01, 3'b000, 32'h11,        1, 3'b001, 1'b1, 32'hFFFF_FF80};
    tbl[2]  = '{32'h3,       32'h80FF_7F01, 3'b100, 32'h22,        2, 3'b010, 1'b1, 32'h0000_0080};
    tbl[3]  = '{32'h2,       32'h80FF_7F01, 3'b001, 32'h33,        3, 3'b100, 1'b1, 32'hFFFF_80FF};
    tbl[4]  = '{32'h1003,    32'h80FF_7F01, 3'b001, 32'h44,        4, 3'b001, 1'b1, 32'hFFFF_80FF};
    tbl[5]  = '{32'h0,       32'h80FF_7F01, 3'b101, 32'h55,        5, 3'b001, 1'b1, 32'h0000_7F01};
    tbl[6]  = '{32'h1,       32'h80FF_7F01, 3'b000, 32'h66,        6, 3'b001, 1'b1, 32'h0000_007F};
    tbl[7]  = '{32'h2,       32'h80FF_7F01, 3'b000, 32'h77,        8, 3'b001, 1'b1, 32'hFFFF_FFFF};
    tbl[8]  = '{32'h1,       32'h80FF_7F01, 3'b010, 32'h88,        9, 3'b001, 1'b1, 32'h80FF_7F01};
    tbl[9]  = '{32'h0,       32'h80FF_7F01, 3'b110, 32'h99,       10, 3'b001, 1'b1, 32'h80FF_7F01};
    tbl[10] = '{32'h2,       32'h80FF_7F01, 3'b111, 32'hAA,       11, 3'b011, 1'b0, 32'h80FF_7F01};
    tbl[11] = '{32'hFFFF_FFF2,32'h80FF_7F01,3'b101, 32'hBB,       31, 3'b111, 1'b1, 32'h0000_80FF};
    va = '{32'h0, 32'hA5A5_0001, 3'b011, 32'hAAAA_0001, 12, 3'b001, 1'b0, 32'hA5A5_0001};
    vb = '{32'h1, 32'hB5B5_0002, 3'b011, 32'hBBBB_0002, 13, 3'b010, 1'b1, 32'hB5B5_0002};
    vc = '{32'h2, 32'hC5C5_0003, 3'b011, 32'hCCCC_0003, 14, 3'b100, 1'b0, 32'hC5C5_0003};
    vd = '{32'h3, 32'hD5D5_0004, 3'b011, 32'hDDDD_0004, 15, 3'b001, 1'b1, 32'hD5D5_0004};

    rst = 1'b1; flush = 1'b0; valid_m = 1'b0; ready_w = 1'b0;
    alu_out_m = '0; ram_data_m = '0; result_m = '0; rd_m = '0;
    reg_write_m = '0; mem_to_reg_m = 1'b0; load_type_m = '0;
    @(negedge clk);
    cycle(); cycle();
    rst = 1'b0;
    chk_zero("reset");

    // Back-to-back pass-through; each entry must appear one cycle later.
    ready_w = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(tbl[i]);
      cycle();
      chk("pass_valid_w", valid_w, 1'b1);
      chk("pass_result_w", result_w, tbl[i].res);
    end
    valid_m = 1'b0;
    cycle();
    chk("pass_drained", valid_w, 1'b0);
    chk("pass_rw_gated", reg_write_w, 3'h0);

    // Backpressure: A in main, B in skid, C held off until space frees.
    ready_w = 1'b0;
    send(va); cycle();
    send(vb); cycle();
    send(vc); cycle(); cycle();
    chk("bp_ready_m_low", ready_m, 1'b0);
    chk("bp_main_is_a", result_w, va.res);
    ready_w = 1'b1;
    cycle();
    chk("bp_ready_m_back", ready_m, 1'b1);
    chk("bp_main_is_b", result_w, vb.res);
    cycle();
    valid_m = 1'b0;
    chk("bp_main_is_c", result_w, vc.res);
    cycle();
    chk("bp_drained", valid_w, 1'b0);
    chk("bp_rw_gated", reg_write_w, 3'h0);
    chk("bp_sb_empty", sb.size(), 0);

    // Full stall with toggling inputs.
    ready_w = 1'b0;
    send(va); cycle();
    send(vb); cycle();
    for (int i = 0; i < 5; i++) begin
      ram_data_m = (i % 2) ? 32'hFFFF_FFFF : 32'h0;
      alu_out_m  = 32'(i);
      result_m   = ~result_m;
      cycle();
      chk("stall_result",   result_w,    va.res);
      chk("stall_load",     load_data_w, va.ld);
      chk("stall_rd",       rd_w,        va.rd);
      chk("stall_rw",       reg_write_w, va.rw);
      chk("stall_ready_m",  ready_m,     1'b0);
    end

    // Flush with both entries full and a new input offered.
    send(vd);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    valid_m = 1'b0;
    chk_zero("flush");
    ready_w = 1'b1;
    cycle();
    chk("flush_dropped", valid_w, 1'b0);

    // Reset in the middle of a stall.
    ready_w = 1'b0;
    send(va); cycle();
    send(vb); cycle();
    send(vc);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    valid_m = 1'b0;
    chk_zero("rst_stall");
    ready_w = 1'b1;
    cycle();
    chk("rst_no_output", valid_w, 1'b0);
    chk("rst_no_rw", reg_write_w, 3'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
